// File: rtl/tx_framer.sv
// -----------------------------------------------------------------------------
// tx_framer -- asynchronous-serial (UART style) transmit framer.
//
// Serialises one word per frame: a start bit (0), DATA_BITS data bits sent
// LSB first, an optional parity bit and STOP_BITS stop bits (1). Bit periods
// are paced by the externally supplied baud_tick. Each tick ends the current
// bit, and the line changes in the following cycle.
//
// Optional feature (compile-time macro TX_HOLD_BUF_EN):
//   When defined, a one-word holding buffer lets a second word be accepted
//   while a frame is in progress. That word is sent back-to-back with no idle
//   gap. When undefined, words are accepted only in IDLE, and the block always
//   spends at least one cycle in IDLE between frames.
//
// Parameters:
//   DATA_BITS  data bits per frame (5..8)
//   STOP_BITS  stop bits per frame (1 or 2)
//
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   baud_tick   in   one-cycle pulse marking each bit-period boundary
//   tx_valid    in   tx_data is offered
//   tx_data     in   word to send, LSB first
//   parity_en   in   append a parity bit to this word
//   parity_odd  in   1 = odd parity, 0 = even parity
//   tx_ready    out  a word can be accepted this cycle
//   txd         out  serial line, idle high
//   busy        out  a frame is in progress (state is not IDLE)
//   tx_done     out  one-cycle pulse on the tick that ends the last stop bit
// -----------------------------------------------------------------------------
module tx_framer #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  // A 3-bit counter covers every legal DATA_BITS value (5..8).
  localparam int                CNT_W     = 3;
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_BITS - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;

  // Word of the frame in progress. The parity bit is computed once, at capture.
  logic [DATA_BITS-1:0] data_q;
  logic                 par_en_q;
  logic                 par_bit_q;

  logic                 accept;
  logic                 stop_end;
  logic                 load_in;     // start a frame from the input port
  logic                 load_buf;    // start a frame from the holding buffer
  logic                 frame_load;
  logic [DATA_BITS-1:0] next_data;
  logic                 next_par_en;
  logic                 next_par_bit;

  assign accept   = tx_valid & tx_ready;
  assign stop_end = (state_q == STOP) & baud_tick & (stop_cnt_q == LAST_STOP);

`ifdef TX_HOLD_BUF_EN
  logic                 buf_full_q;
  logic [DATA_BITS-1:0] buf_data_q;
  logic                 buf_par_en_q;
  logic                 buf_par_bit_q;
  logic                 buf_fill;

  // A word bypasses the buffer when it can start a frame right away: in IDLE,
  // or on the tick that ends a frame while nothing is waiting. This keeps the
  // buffer from ever holding a word while the state is IDLE.
  assign load_buf = stop_end & buf_full_q;
  assign load_in  = accept & ((state_q == IDLE) | (stop_end & ~buf_full_q));
  assign buf_fill = accept & ~load_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_full_q <= 1'b0;
    end else if (load_buf) begin
      buf_full_q <= 1'b0;
    end else if (buf_fill) begin
      buf_full_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_fill) begin
      buf_data_q    <= tx_data;
      buf_par_en_q  <= parity_en;
      buf_par_bit_q <= (^tx_data) ^ parity_odd;
    end
  end

  assign next_data    = load_buf ? buf_data_q    : tx_data;
  assign next_par_en  = load_buf ? buf_par_en_q  : parity_en;
  assign next_par_bit = load_buf ? buf_par_bit_q : ((^tx_data) ^ parity_odd);
`else
  assign load_buf     = 1'b0;
  assign load_in      = accept;
  assign next_data    = tx_data;
  assign next_par_en  = parity_en;
  assign next_par_bit = (^tx_data) ^ parity_odd;
`endif

  assign frame_load = load_in | load_buf;

  // Frame word: captured only when a frame starts, so later changes on
  // tx_data cannot disturb the frame in progress.
  always_ff @(posedge clk) begin
    if (frame_load) begin
      data_q    <= next_data;
      par_en_q  <= next_par_en;
      par_bit_q <= next_par_bit;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    unique case (state_q)
      // Ticks in IDLE are ignored, including one coincident with acceptance.
      IDLE: begin
        if (load_in) state_d = START;
      end
      START: begin
        if (baud_tick) state_d = DATA;
      end
      DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (baud_tick) state_d = STOP;
      end
      STOP: begin
        if (baud_tick) begin
          if (stop_cnt_q == LAST_STOP) begin
            stop_cnt_d = 1'b0;
            state_d    = frame_load ? START : IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    txd     = 1'b1;
    busy    = (state_q != IDLE);
    tx_done = stop_end;
`ifdef TX_HOLD_BUF_EN
    tx_ready = ~buf_full_q;
`else
    tx_ready = (state_q == IDLE);
`endif
    unique case (state_q)
      IDLE:    txd = 1'b1;
      START:   txd = 1'b0;
      DATA:    txd = data_q[bit_cnt_q];
      PARITY:  txd = par_bit_q;
      STOP:    txd = 1'b1;
      default: txd = 1'b1;
    endcase
  end

endmodule
